// File: rtl/zero_pad_stream_2d.sv
// Four-sided constant padding around CHANNELS-interleaved pixel frames, zero latency by default.
// Define ZERO_PAD_STREAM_OUT_REG_EN to register the outputs through a 2-entry skid buffer.
module zero_pad_stream_2d #(
    parameter int STREAM_WIDTH = 8,
    parameter int CHANNELS     = 1,
    parameter int INPUT_HEIGHT = 224,
    parameter int INPUT_WIDTH  = 224,
    parameter int PAD_TOP      = 1,
    parameter int PAD_BOTTOM   = 1,
    parameter int PAD_LEFT     = 1,
    parameter int PAD_RIGHT    = 1,
    parameter logic [STREAM_WIDTH-1:0] PAD_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STREAM_WIDTH-1:0] stream_in,
    input  logic                    stream_in_valid,
    output logic                    stream_in_ready,
    output logic [STREAM_WIDTH-1:0] stream_out,
    output logic                    stream_out_valid,
    input  logic                    stream_out_ready,
    output logic                    stream_out_last
);
    localparam int OUTPUT_HEIGHT = INPUT_HEIGHT + PAD_TOP + PAD_BOTTOM;
    localparam int OUTPUT_WIDTH  = INPUT_WIDTH + PAD_LEFT + PAD_RIGHT;
    localparam int CH_W  = $clog2(CHANNELS + 1);
    localparam int COL_W = $clog2(OUTPUT_WIDTH + 1);
    localparam int ROW_W = $clog2(OUTPUT_HEIGHT + 1);

    generate
        if (CHANNELS < 1) begin : g_bad_channels
            $error("zero_pad_stream_2d: CHANNELS must be >= 1");
        end
        if (PAD_TOP < 0 || PAD_BOTTOM < 0 || PAD_LEFT < 0 || PAD_RIGHT < 0) begin : g_bad_pad
            $error("zero_pad_stream_2d: pad sizes must be >= 0");
        end
        if (INPUT_HEIGHT < 1 || INPUT_WIDTH < 1) begin : g_bad_dims
            $error("zero_pad_stream_2d: input dimensions must be >= 1");
        end
    endgenerate

    logic [CH_W-1:0]  ch;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [31:0]      row_w, col_w;
    logic             ch_end, col_end, row_end, frame_end;
    logic             op_data, adv;

    assign ch_end    = (ch == CH_W'(CHANNELS - 1));
    assign col_end   = (col == COL_W'(OUTPUT_WIDTH - 1));
    assign row_end   = (row == ROW_W'(OUTPUT_HEIGHT - 1));
    assign frame_end = row_end && col_end && ch_end;

    // Widened to 32 bits so the lower bound never underflows when a pad is 0.
    assign row_w   = 32'(row);
    assign col_w   = 32'(col);
    assign op_data = (row_w >= 32'(PAD_TOP))  && (row_w < 32'(PAD_TOP + INPUT_HEIGHT)) &&
                     (col_w >= 32'(PAD_LEFT)) && (col_w < 32'(PAD_LEFT + INPUT_WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            ch  <= '0;
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (ch_end) begin
                ch <= '0;
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end else begin
                ch <= ch + CH_W'(1);
            end
        end
    end

`ifdef ZERO_PAD_STREAM_OUT_REG_EN
    logic [STREAM_WIDTH-1:0] core_data, data_p1, skid_data_p1;
    logic                    core_vld, core_last;
    logic                    vld_p1, last_p1, skid_vld_p1, skid_last_p1;
    logic                    pop;

    assign core_data = op_data ? stream_in : PAD_VALUE;
    assign core_vld  = op_data ? stream_in_valid : 1'b1;
    assign core_last = frame_end;

    // Acceptance looks only at the registered skid flag, so no ready path crosses the block.
    assign adv             = core_vld & ~skid_vld_p1;
    assign stream_in_ready = op_data & ~skid_vld_p1;
    assign pop             = vld_p1 & stream_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (pop) begin
            if (skid_vld_p1) begin
                skid_vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= adv;
            end
        end else if (adv) begin
            if (vld_p1) begin
                skid_vld_p1 <= 1'b1;
            end else begin
                vld_p1 <= 1'b1;
            end
        end
    end

    // ---- stage p1: output and skid registers ----
    always_ff @(posedge clk) begin
        if (pop && skid_vld_p1) begin
            data_p1 <= skid_data_p1;
            last_p1 <= skid_last_p1;
        end else if (adv && (pop || !vld_p1)) begin
            data_p1 <= core_data;
            last_p1 <= core_last;
        end
        if (adv && vld_p1 && !pop) begin
            skid_data_p1 <= core_data;
            skid_last_p1 <= core_last;
        end
    end

    assign stream_out       = data_p1;
    assign stream_out_valid = vld_p1;
    assign stream_out_last  = last_p1;
`else
    assign stream_out       = op_data ? stream_in : PAD_VALUE;
    assign stream_out_valid = op_data ? stream_in_valid : 1'b1;
    assign stream_in_ready  = op_data & stream_out_ready;
    assign adv              = op_data ? (stream_in_valid & stream_out_ready) : stream_out_ready;
    assign stream_out_last  = frame_end;
`endif

endmodule

// File: tb/tb_zero_pad_stream_2d.sv
// Bench for zero_pad_stream_2d: four configurations side by side, each checked beat by beat
// against an arithmetic model of the padded frame, under steady and randomised handshakes.
module tb_zero_pad_stream_2d;
    localparam int N = 4;
    // Instances: 0 = 2x2 all pads 1, 1 = 3x3 no pads, 2 = 1x1 CH3 left pad, 3 = 1x2 top pad 2 PAD FF
    localparam int CFG_CH [N] = '{1, 1, 3, 1};
    localparam int CFG_IH [N] = '{2, 3, 1, 1};
    localparam int CFG_IW [N] = '{2, 3, 1, 2};
    localparam int CFG_PT [N] = '{1, 0, 0, 2};
    localparam int CFG_PB [N] = '{1, 0, 0, 0};
    localparam int CFG_PL [N] = '{1, 0, 1, 0};
    localparam int CFG_PR [N] = '{1, 0, 0, 0};
    localparam int CFG_PV [N] = '{0, 0, 0, 255};

    localparam logic [7:0] REF_A [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00,
                                          8'h00, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] REF_C [6]  = '{8'h00, 8'h00, 8'h00, 8'h0A, 8'h0B, 8'h0C};
    localparam logic [7:0] REF_D [12] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05, 8'h06,
                                          8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05, 8'h06};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sin   [N];
    logic       sin_v [N];
    logic       sin_r [N];
    logic [7:0] sout  [N];
    logic       sout_v[N];
    logic       sout_r[N];
    logic       sout_l[N];

    int         checks = 0;
    int         errors = 0;
    int         n_out  [N];
    int         in_idx [N];
    bit         in_hs  [N];
    bit         prev_hold[N];
    logic [7:0] prev_data[N];
    logic       prev_last[N];
    bit         rnd = 1'b0;

    always #5 clk = ~clk;

    zero_pad_stream_2d #(.STREAM_WIDTH(8), .CHANNELS(CFG_CH[0]), .INPUT_HEIGHT(CFG_IH[0]),
        .INPUT_WIDTH(CFG_IW[0]), .PAD_TOP(CFG_PT[0]), .PAD_BOTTOM(CFG_PB[0]), .PAD_LEFT(CFG_PL[0]),
        .PAD_RIGHT(CFG_PR[0]), .PAD_VALUE(8'(CFG_PV[0]))) u_a (
        .clk(clk), .rst(rst), .stream_in(sin[0]), .stream_in_valid(sin_v[0]), .stream_in_ready(sin_r[0]),
        .stream_out(sout[0]), .stream_out_valid(sout_v[0]), .stream_out_ready(sout_r[0]),
        .stream_out_last(sout_l[0]));

    zero_pad_stream_2d #(.STREAM_WIDTH(8), .CHANNELS(CFG_CH[1]), .INPUT_HEIGHT(CFG_IH[1]),
        .INPUT_WIDTH(CFG_IW[1]), .PAD_TOP(CFG_PT[1]), .PAD_BOTTOM(CFG_PB[1]), .PAD_LEFT(CFG_PL[1]),
        .PAD_RIGHT(CFG_PR[1]), .PAD_VALUE(8'(CFG_PV[1]))) u_b (
        .clk(clk), .rst(rst), .stream_in(sin[1]), .stream_in_valid(sin_v[1]), .stream_in_ready(sin_r[1]),
        .stream_out(sout[1]), .stream_out_valid(sout_v[1]), .stream_out_ready(sout_r[1]),
        .stream_out_last(sout_l[1]));

    zero_pad_stream_2d #(.STREAM_WIDTH(8), .CHANNELS(CFG_CH[2]), .INPUT_HEIGHT(CFG_IH[2]),
        .INPUT_WIDTH(CFG_IW[2]), .PAD_TOP(CFG_PT[2]), .PAD_BOTTOM(CFG_PB[2]), .PAD_LEFT(CFG_PL[2]),
        .PAD_RIGHT(CFG_PR[2]), .PAD_VALUE(8'(CFG_PV[2]))) u_c (
        .clk(clk), .rst(rst), .stream_in(sin[2]), .stream_in_valid(sin_v[2]), .stream_in_ready(sin_r[2]),
        .stream_out(sout[2]), .stream_out_valid(sout_v[2]), .stream_out_ready(sout_r[2]),
        .stream_out_last(sout_l[2]));

    zero_pad_stream_2d #(.STREAM_WIDTH(8), .CHANNELS(CFG_CH[3]), .INPUT_HEIGHT(CFG_IH[3]),
        .INPUT_WIDTH(CFG_IW[3]), .PAD_TOP(CFG_PT[3]), .PAD_BOTTOM(CFG_PB[3]), .PAD_LEFT(CFG_PL[3]),
        .PAD_RIGHT(CFG_PR[3]), .PAD_VALUE(8'(CFG_PV[3]))) u_d (
        .clk(clk), .rst(rst), .stream_in(sin[3]), .stream_in_valid(sin_v[3]), .stream_in_ready(sin_r[3]),
        .stream_out(sout[3]), .stream_out_valid(sout_v[3]), .stream_out_ready(sout_r[3]),
        .stream_out_last(sout_l[3]));

    function automatic int frame_len(input int i);
        return CFG_CH[i] * (CFG_IH[i] + CFG_PT[i] + CFG_PB[i]) * (CFG_IW[i] + CFG_PL[i] + CFG_PR[i]);
    endfunction

    // Value of the idx-th input beat fed to instance i (idx counts from the last reset).
    function automatic logic [7:0] in_val(input int i, input int idx);
        case (i)
            2:       return 8'(10 + idx % 3);
            3:       return 8'(5 + idx % 2);
            default: return 8'(idx + 1);
        endcase
    endfunction

    // Expected n-th accepted output beat of instance i, from its position in the padded frame.
    function automatic logic [7:0] exp_data(input int i, input int n);
        int f, k, ch, pix, col, row, ow, idx;
        ow  = CFG_IW[i] + CFG_PL[i] + CFG_PR[i];
        f   = frame_len(i);
        k   = n % f;
        ch  = k % CFG_CH[i];
        pix = k / CFG_CH[i];
        col = pix % ow;
        row = pix / ow;
        if (row >= CFG_PT[i] && row < CFG_PT[i] + CFG_IH[i] &&
            col >= CFG_PL[i] && col < CFG_PL[i] + CFG_IW[i]) begin
            idx = (n / f) * CFG_IH[i] * CFG_IW[i] * CFG_CH[i]
                + ((row - CFG_PT[i]) * CFG_IW[i] + (col - CFG_PL[i])) * CFG_CH[i] + ch;
            return in_val(i, idx);
        end
        return 8'(CFG_PV[i]);
    endfunction

    function automatic logic exp_last(input int i, input int n);
        return (n % frame_len(i)) == frame_len(i) - 1;
    endfunction

    // One clock: compare at the falling edge, then drive new inputs just after the rising edge.
    task automatic tick();
        bit was_rst;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            in_hs[i] = sin_v[i] && sin_r[i];
            if (!rst) begin
                if (prev_hold[i]) begin
                    checks++;
                    if (sout_v[i] !== 1'b1 || sout[i] !== prev_data[i] || sout_l[i] !== prev_last[i]) begin
                        errors++;
                        $display("FAIL hold[%0d] got valid=%0b data=%02h last=%0b required valid=1 data=%02h last=%0b",
                                 i, sout_v[i], sout[i], sout_l[i], prev_data[i], prev_last[i]);
                    end
                end
                if (sout_v[i] && sout_r[i]) begin
                    checks++;
                    if (sout[i] !== exp_data(i, n_out[i]) || sout_l[i] !== exp_last(i, n_out[i])) begin
                        errors++;
                        $display("FAIL beat[%0d] #%0d got data=%02h last=%0b required data=%02h last=%0b",
                                 i, n_out[i], sout[i], sout_l[i], exp_data(i, n_out[i]), exp_last(i, n_out[i]));
                    end
                    n_out[i]++;
                end
                prev_hold[i] = sout_v[i] && !sout_r[i];
                prev_data[i] = sout[i];
                prev_last[i] = sout_l[i];
            end else begin
                prev_hold[i] = 1'b0;
            end
        end
        @(posedge clk);
        was_rst = rst;
        #1;
        for (int i = 0; i < N; i++) begin
            if (was_rst) begin
                n_out[i]  = 0;
                in_idx[i] = 0;
            end else if (in_hs[i]) begin
                in_idx[i]++;
            end
            if (was_rst || !sin_v[i] || in_hs[i])
                sin_v[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            sin[i]    = in_val(i, in_idx[i]);
            sout_r[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic run_frames(input int frames, input int budget);
        int tgt[N];
        int cyc;
        bit done;
        for (int i = 0; i < N; i++) tgt[i] = n_out[i] + frames * frame_len(i);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
            done = 1'b1;
            for (int i = 0; i < N; i++) if (n_out[i] < tgt[i]) done = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (n_out[i] < tgt[i]) begin
                errors++;
                $display("FAIL frames[%0d] got %0d beats required %0d", i, n_out[i], tgt[i]);
            end
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0b required %0b", name, got, req);
        end
    endtask

    initial begin
        int cyc;
        // Pin the model against hand-computed frames.
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (exp_data(0, k) !== REF_A[k] || exp_last(0, k) !== (k == 15)) begin
                errors++;
                $display("FAIL model_a #%0d got %02h required %02h", k, exp_data(0, k), REF_A[k]);
            end
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (exp_data(1, k) !== 8'(k + 1) || exp_last(1, k) !== (k == 8)) begin
                errors++;
                $display("FAIL model_b #%0d got %02h required %02h", k, exp_data(1, k), 8'(k + 1));
            end
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (exp_data(2, k) !== REF_C[k] || exp_last(2, k) !== (k == 5)) begin
                errors++;
                $display("FAIL model_c #%0d got %02h required %02h", k, exp_data(2, k), REF_C[k]);
            end
        end
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (exp_data(3, k) !== REF_D[k] || exp_last(3, k) !== (k % 6 == 5)) begin
                errors++;
                $display("FAIL model_d #%0d got %02h required %02h", k, exp_data(3, k), REF_D[k]);
            end
        end

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            sin[i] = 8'h00; sin_v[i] = 1'b0; sout_r[i] = 1'b1;
            n_out[i] = 0; in_idx[i] = 0; prev_hold[i] = 1'b0;
            prev_data[i] = 8'h00; prev_last[i] = 1'b0; in_hs[i] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        #2;
        check_bit("reset_ready_a", sin_r[0], 1'b0);
        check_bit("reset_ready_b", sin_r[1], 1'b1);
        check_bit("reset_ready_c", sin_r[2], 1'b0);
        check_bit("reset_ready_d", sin_r[3], 1'b0);

        rnd = 1'b0;
        run_frames(2, 200);
        rnd = 1'b1;
        run_frames(3, 3000);

        // Abandon a frame of instance 0 after five beats.
        cyc = 0;
        while ((n_out[0] % 16) != 5 && cyc < 500) begin
            tick();
            cyc++;
        end
        checks++;
        if ((n_out[0] % 16) != 5) begin
            errors++;
            $display("FAIL midframe_reach got beat %0d required 5", n_out[0] % 16);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        check_bit("post_reset_ready_a", sin_r[0], 1'b0);
        run_frames(2, 3000);
        rnd = 1'b0;
        run_frames(1, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
